// File: rtl/shutdown_sequencer.sv
// Staged actuator sequencer: powers NUM_STAGES channels up in ascending order
// and down in descending order, waiting for feedback plus a settle delay on
// every step. Missing/lost feedback forces all channels off and latches a
// fault that only an explicit clear (with the machine stopped) releases.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   shutdown_req  level request to stop the machine
//   stage_fb      per-channel energised feedback (pre-synchronised)
//   fault_clr     single-cycle fault clear pulse
//   stage_en      registered per-channel enable
//   busy          sequencing up or down
//   all_on        all channels on and confirmed
//   all_off       idle with all channels off
//   seq_fault     fault latched
//   fault_stage   channel index responsible for the last fault
module shutdown_sequencer #(
  parameter int unsigned NUM_STAGES      = 4,
  parameter int unsigned STAGE_DELAY_CYC = 240000,
  parameter int unsigned CONFIRM_TO_CYC  = 2400000,
  parameter int unsigned CNT_WIDTH       = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shutdown_req,
  input  logic [NUM_STAGES-1:0] stage_fb,
  input  logic                  fault_clr,
  output logic [NUM_STAGES-1:0] stage_en,
  output logic                  busy,
  output logic                  all_on,
  output logic                  all_off,
  output logic                  seq_fault,
  output logic [2:0]            fault_stage
);

  localparam int unsigned IDX_W = 3;
  localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_STAGES - 1);
  localparam logic [CNT_WIDTH-1:0] CONFIRM_END = CNT_WIDTH'(CONFIRM_TO_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] SETTLE_END  = CNT_WIDTH'(STAGE_DELAY_CYC - 1);
  localparam logic [NUM_STAGES-1:0] ONE_HOT0   = NUM_STAGES'(1);

  typedef enum logic [2:0] {
    S_OFF,
    S_PWR_UP,
    S_ON,
    S_PWR_DOWN,
    S_FAULT
  } state_e;

  typedef enum logic {
    PH_CONFIRM,
    PH_SETTLE
  } phase_e;

  state_e                 state_q, state_d;
  phase_e                 phase_q, phase_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [NUM_STAGES-1:0]  stage_en_q, stage_en_d;
  logic                   busy_q, busy_d;
  logic                   all_on_q, all_on_d;
  logic                   all_off_q, all_off_d;
  logic                   seq_fault_q, seq_fault_d;
  logic [2:0]             fault_stage_q, fault_stage_d;

  logic                   fb_cur_c;
  logic [IDX_W-1:0]       low_idx_c;
  logic [IDX_W-1:0]       idx_inc_c;
  logic [IDX_W-1:0]       idx_dec_c;

  // Feedback of the channel currently being sequenced.
  assign fb_cur_c  = |(stage_fb & (ONE_HOT0 << idx_q));
  assign idx_inc_c = idx_q + IDX_W'(1);
  assign idx_dec_c = idx_q - IDX_W'(1);

  // Lowest channel whose feedback is low (descending scan, last write wins).
  always_comb begin
    low_idx_c = '0;
    for (int i = int'(NUM_STAGES) - 1; i >= 0; i--) begin
      if ((stage_fb & (ONE_HOT0 << i)) == '0) begin
        low_idx_c = IDX_W'(i);
      end
    end
  end

  // State register and datapath flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_OFF;
      phase_q       <= PH_CONFIRM;
      idx_q         <= '0;
      cnt_q         <= '0;
      stage_en_q    <= '0;
      busy_q        <= 1'b0;
      all_on_q      <= 1'b0;
      all_off_q     <= 1'b1;
      seq_fault_q   <= 1'b0;
      fault_stage_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      stage_en_q    <= stage_en_d;
      busy_q        <= busy_d;
      all_on_q      <= all_on_d;
      all_off_q     <= all_off_d;
      seq_fault_q   <= seq_fault_d;
      fault_stage_q <= fault_stage_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    stage_en_d    = stage_en_q;
    fault_stage_d = fault_stage_q;

    case (state_q)
      S_OFF: begin
        if (!shutdown_req) begin
          state_d    = S_PWR_UP;
          phase_d    = PH_CONFIRM;
          idx_d      = '0;
          cnt_d      = '0;
          stage_en_d = ONE_HOT0;
        end
      end

      S_PWR_UP: begin
        if (shutdown_req) begin
          // Abort power-up: drop the channel in progress, then walk down.
          state_d    = S_PWR_DOWN;
          phase_d    = PH_CONFIRM;
          cnt_d      = '0;
          stage_en_d = stage_en_q & ~(ONE_HOT0 << idx_q);
        end else if (phase_q == PH_CONFIRM) begin
          if (fb_cur_c) begin
            phase_d = PH_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == CONFIRM_END) begin
            state_d       = S_FAULT;
            cnt_d         = '0;
            stage_en_d    = '0;
            fault_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          if (cnt_q == SETTLE_END) begin
            cnt_d = '0;
            if (idx_q < IDX_LAST) begin
              idx_d      = idx_inc_c;
              phase_d    = PH_CONFIRM;
              stage_en_d = stage_en_q | (ONE_HOT0 << idx_inc_c);
            end else begin
              state_d = S_ON;
              phase_d = PH_CONFIRM;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      S_ON: begin
        // Lost feedback wins over a simultaneous shutdown request.
        if (stage_fb != '1) begin
          state_d       = S_FAULT;
          cnt_d         = '0;
          stage_en_d    = '0;
          fault_stage_d = low_idx_c;
        end else if (shutdown_req) begin
          state_d    = S_PWR_DOWN;
          phase_d    = PH_CONFIRM;
          idx_d      = IDX_LAST;
          cnt_d      = '0;
          stage_en_d = stage_en_q & ~(ONE_HOT0 << IDX_LAST);
        end
      end

      S_PWR_DOWN: begin
        // shutdown_req is deliberately ignored: a shutdown always completes.
        if (phase_q == PH_CONFIRM) begin
          if (!fb_cur_c) begin
            phase_d = PH_SETTLE;
            cnt_d   = '0;
          end else if (cnt_q == CONFIRM_END) begin
            state_d       = S_FAULT;
            cnt_d         = '0;
            stage_en_d    = '0;
            fault_stage_d = idx_q;
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end else begin
          if (cnt_q == SETTLE_END) begin
            cnt_d = '0;
            if (idx_q != '0) begin
              idx_d      = idx_dec_c;
              phase_d    = PH_CONFIRM;
              stage_en_d = stage_en_q & ~(ONE_HOT0 << idx_dec_c);
            end else begin
              state_d = S_OFF;
              phase_d = PH_CONFIRM;
            end
          end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
          end
        end
      end

      S_FAULT: begin
        stage_en_d = '0;
        // Release only with the machine stopped and every channel confirmed off.
        if (fault_clr && shutdown_req && (stage_fb == '0)) begin
          state_d = S_OFF;
          phase_d = PH_CONFIRM;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d    = S_OFF;
        phase_d    = PH_CONFIRM;
        idx_d      = '0;
        cnt_d      = '0;
        stage_en_d = '0;
      end
    endcase

    busy_d      = (state_d == S_PWR_UP) || (state_d == S_PWR_DOWN);
    all_on_d    = (state_d == S_ON);
    all_off_d   = (state_d == S_OFF);
    seq_fault_d = (state_d == S_FAULT);
  end

  assign stage_en    = stage_en_q;
  assign busy        = busy_q;
  assign all_on      = all_on_q;
  assign all_off     = all_off_q;
  assign seq_fault   = seq_fault_q;
  assign fault_stage = fault_stage_q;

endmodule

// File: tb/tb_shutdown_sequencer.sv
// Bench for shutdown_sequencer: directed scenarios plus randomized feedback,
// all compared cycle by cycle against a behavioural model built from
// countdown timers and a count of energised channels.
module tb_shutdown_sequencer;

  localparam int unsigned NS = 3;
  localparam int unsigned SD = 4;
  localparam int unsigned CT = 8;
  localparam int unsigned CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          shutdown_req;
  logic [NS-1:0] stage_fb;
  logic          fault_clr;
  logic [NS-1:0] stage_en;
  logic          busy;
  logic          all_on;
  logic          all_off;
  logic          seq_fault;
  logic [2:0]    fault_stage;

  always #5 clk = ~clk;

  shutdown_sequencer #(
    .NUM_STAGES      (NS),
    .STAGE_DELAY_CYC (SD),
    .CONFIRM_TO_CYC  (CT),
    .CNT_WIDTH       (CW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .shutdown_req (shutdown_req),
    .stage_fb     (stage_fb),
    .fault_clr    (fault_clr),
    .stage_en     (stage_en),
    .busy         (busy),
    .all_on       (all_on),
    .all_off      (all_off),
    .seq_fault    (seq_fault),
    .fault_stage  (fault_stage)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_FULL = 2;
  localparam int M_FALL = 3;
  localparam int M_TRIP = 4;

  int m_mode;     // what the machine is doing
  int m_ch;       // channel being switched
  int m_n;        // number of channels energised (always the lowest m_n)
  int m_left;     // cycles left in current wait
  bit m_waitfb;   // waiting for feedback (1) or settling (0)
  int m_fault;

  function automatic bit fb_of(input logic [NS-1:0] fb, input int ch);
    logic [NS-1:0] t;
    t = fb >> ch;
    return t[0];
  endfunction

  function automatic logic [NS-1:0] exp_en();
    return NS'((1 << m_n) - 1);
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ch = 0; m_n = 0; m_left = 0; m_waitfb = 1'b0; m_fault = 0;
  endtask

  task automatic wait_fb();
    m_waitfb = 1'b1;
    m_left   = CT;
  endtask

  task automatic trip(input int ch);
    m_mode  = M_TRIP;
    m_fault = ch;
    m_n     = 0;
  endtask

  task automatic model_edge(input logic sd, input logic [NS-1:0] fb, input logic clr);
    int lz;
    case (m_mode)
      M_IDLE: if (!sd) begin
        m_mode = M_RISE; m_ch = 0; m_n = 1; wait_fb();
      end
      M_RISE: begin
        if (sd) begin
          m_mode = M_FALL; m_n = m_ch; wait_fb();
        end else if (m_waitfb) begin
          if (fb_of(fb, m_ch)) begin m_waitfb = 1'b0; m_left = SD; end
          else if (m_left == 1) trip(m_ch);
          else m_left--;
        end else if (m_left == 1) begin
          if (m_ch < int'(NS) - 1) begin m_ch++; m_n = m_ch + 1; wait_fb(); end
          else m_mode = M_FULL;
        end else m_left--;
      end
      M_FULL: begin
        if (fb != '1) begin
          lz = -1;
          for (int i = 0; i < int'(NS); i++) if (lz < 0 && !fb_of(fb, i)) lz = i;
          trip(lz);
        end else if (sd) begin
          m_mode = M_FALL; m_ch = NS - 1; m_n = NS - 1; wait_fb();
        end
      end
      M_FALL: begin
        if (m_waitfb) begin
          if (!fb_of(fb, m_ch)) begin m_waitfb = 1'b0; m_left = SD; end
          else if (m_left == 1) trip(m_ch);
          else m_left--;
        end else if (m_left == 1) begin
          if (m_ch > 0) begin m_ch--; m_n = m_ch; wait_fb(); end
          else m_mode = M_IDLE;
        end else m_left--;
      end
      default: if (clr && sd && fb == '0) m_mode = M_IDLE;
    endcase
  endtask

  function automatic logic [31:0] exp_vec();
    return 32'({exp_en(), m_mode == M_RISE || m_mode == M_FALL, m_mode == M_FULL,
                m_mode == M_IDLE, m_mode == M_TRIP, 3'(m_fault)});
  endfunction

  function automatic logic [31:0] dut_vec();
    return 32'({stage_en, busy, all_on, all_off, seq_fault, fault_stage});
  endfunction

  // ---------------- feedback stimulus ----------------
  logic [NS-1:0] fb_state;
  logic [NS-1:0] force_lo;
  logic [NS-1:0] force_hi;
  bit            lag_mode;

  // Feedback follows the model's enables, either immediately or with a
  // random per-bit lag and rare spurious flips.
  task automatic update_fb();
    logic [NS-1:0] tgt;
    logic [NS-1:0] m;
    tgt = exp_en();
    if (lag_mode) begin
      for (int i = 0; i < int'(NS); i++) begin
        m = NS'(1 << i);
        if (((fb_state ^ tgt) & m) != '0 && $urandom_range(0, 1) == 1)
          fb_state = (fb_state & ~m) | (tgt & m);
        if ($urandom_range(0, 511) == 0) fb_state = fb_state ^ m;
      end
    end else begin
      fb_state = tgt;
    end
    stage_fb = (fb_state & ~force_lo) | force_hi;
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge(shutdown_req, stage_fb, fault_clr);
    #1;
    check(tag, dut_vec(), exp_vec());
    update_fb();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; shutdown_req = 1'b1; fault_clr = 1'b0;
    force_lo = '0; force_hi = '0; lag_mode = 1'b0; fb_state = '0; stage_fb = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", dut_vec(), 32'({3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000}));
    rst_n = 1'b1;
  endtask

  task automatic pulse_clr(input string tag);
    fault_clr = 1'b1;
    cycle(tag);
    fault_clr = 1'b0;
  endtask

  initial begin
    do_reset();

    // 1: power-up with feedback tied to enables
    shutdown_req = 1'b0;
    for (int k = 0; k < 16; k++) begin
      cycle("s1_model");
      if (k == 0)  check("s1_step0", 32'({stage_en, busy}), 32'({3'b001, 1'b1}));
      if (k == 5)  check("s1_step1", 32'(stage_en), 32'(3'b011));
      if (k == 10) check("s1_step2", 32'(stage_en), 32'(3'b111));
      if (k == 14) check("s1_busy_last", 32'({busy, all_on}), 32'(2'b10));
      if (k == 15) check("s1_all_on", 32'({busy, all_on}), 32'(2'b01));
    end

    // 2: power-down from ON
    shutdown_req = 1'b1;
    for (int k = 0; k < 16; k++) begin
      cycle("s2_model");
      if (k == 0)  check("s2_step0", 32'(stage_en), 32'(3'b011));
      if (k == 5)  check("s2_step1", 32'(stage_en), 32'(3'b001));
      if (k == 10) check("s2_step2", 32'(stage_en), 32'(3'b000));
      if (k == 14) check("s2_not_off", 32'(all_off), 32'd0);
      if (k == 15) check("s2_all_off", 32'(all_off), 32'd1);
    end

    // 4: feedback loss and shutdown together while ON
    shutdown_req = 1'b0;
    repeat (16) cycle("s4_up");
    check("s4_on", 32'(all_on), 32'd1);
    force_lo = 3'b100;
    shutdown_req = 1'b1;
    update_fb();
    cycle("s4_model");
    check("s4_fault", 32'({stage_en, seq_fault, busy, fault_stage}), 32'({3'b000, 1'b1, 1'b0, 3'd2}));

    // 5: clear rules
    shutdown_req = 1'b0;
    pulse_clr("s5_clr_ignored");
    check("s5_still_fault", 32'(seq_fault), 32'd1);
    repeat (2) cycle("s5_hold");
    shutdown_req = 1'b1;
    force_lo = '0;
    update_fb();
    cycle("s5_hold2");
    pulse_clr("s5_clr_ok");
    check("s5_released", 32'({all_off, seq_fault, fault_stage}), 32'({1'b1, 1'b0, 3'd2}));

    // 3: stage 1 never confirms during power-up
    force_lo = 3'b010;
    shutdown_req = 1'b0;
    update_fb();
    for (int k = 0; k < 14; k++) begin
      cycle("s3_model");
      if (k == 12) check("s3_pre_timeout", 32'({stage_en, seq_fault}), 32'({3'b011, 1'b0}));
      if (k == 13) check("s3_timeout", 32'({stage_en, seq_fault, fault_stage}), 32'({3'b000, 1'b1, 3'd1}));
    end
    shutdown_req = 1'b1;
    force_lo = '0;
    update_fb();
    cycle("s3_hold");
    pulse_clr("s3_clr");
    check("s3_off", 32'(all_off), 32'd1);

    // 6: shutdown during power-up, then reset mid-sequence
    shutdown_req = 1'b0;
    repeat (6) cycle("s6_up");
    check("s6_at_idx1", 32'(stage_en), 32'(3'b011));
    shutdown_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      cycle("s6_model");
      if (k == 0)  check("s6_drop1", 32'({stage_en, busy}), 32'({3'b001, 1'b1}));
      if (k == 5)  check("s6_drop0", 32'(stage_en), 32'(3'b000));
      if (k == 10) check("s6_off", 32'(all_off), 32'd1);
    end
    shutdown_req = 1'b0;
    repeat (7) cycle("s6_up2");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("s6_async_reset", dut_vec(), 32'({3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b000}));
    shutdown_req = 1'b1;
    fb_state = '0;
    stage_fb = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Randomized: lagging feedback, random requests and clears
    lag_mode = 1'b1;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 49) == 0) shutdown_req = ~shutdown_req;
      fault_clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 399) == 0) force_lo = NS'($urandom_range(1, 7));
      else if ($urandom_range(0, 39) == 0) force_lo = '0;
      stage_fb = (fb_state & ~force_lo) | force_hi;
      cycle("rand_model");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
